// File: rtl/seg_display_pkg.sv
// Shared types, constants and segment decode for the seven-segment display back end.
package seg_display_pkg;

  typedef enum logic [2:0] {
    MODE_HEX = 3'd0,
    MODE_CLK = 3'd1,
    MODE_I   = 3'd2,
    MODE_R   = 3'd3,
    MODE_J   = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_LOAD  = 2'd1,
    CONV_SHIFT = 2'd2,
    CONV_DONE  = 2'd3
  } conv_state_t;

  localparam int NUM_MODES  = 5;
  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_C   = 8'hC6;
  localparam logic [7:0] GLYPH_1   = 8'hF9;
  localparam logic [7:0] GLYPH_R   = 8'hAF;
  localparam logic [7:0] GLYPH_J   = 8'hE1;

  // Entry n sits at bits [8n+7:8n]; codes are active-low {dp,g,f,e,d,c,b,a}.
  localparam logic [127:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex2seg(input logic [3:0] nibble);
    return SEG_TABLE[{nibble, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] mode_glyph(input mode_t m);
    logic [7:0] g;
    case (m)
      MODE_CLK: g = GLYPH_C;
      MODE_I:   g = GLYPH_1;
      MODE_R:   g = GLYPH_R;
      MODE_J:   g = GLYPH_J;
      default:  g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_display_if.sv
// Signal bundle between the CPU-side sources and the display driver.
interface seg_display_if;
  import seg_display_pkg::*;

  logic        mode_btn;
  logic [31:0] hex;
  logic [10:0] cnt_clk;
  logic [10:0] cnt_i;
  logic [10:0] cnt_r;
  logic [10:0] cnt_j;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [2:0]  mode;
  conv_state_t conv_state;

  modport master (
    output mode_btn, hex, cnt_clk, cnt_i, cnt_r, cnt_j,
    input  seg, an, mode, conv_state
  );

  modport slave (
    input  mode_btn, hex, cnt_clk, cnt_i, cnt_r, cnt_j,
    output seg, an, mode, conv_state
  );

endinterface

// File: rtl/seg_display_bin2bcd_seq.sv
// Sequential 11-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
module bin2bcd_seq
  import seg_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [10:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output conv_state_t state_dbg
);

  conv_state_t state, state_next;
  logic [26:0] sr;
  logic [26:0] sr_adj;
  logic [3:0]  iter;

  function automatic logic [15:0] dabble(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < 4; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign sr_adj    = {dabble(sr[26:11]), sr[10:0]};
  assign bcd       = sr[26:11];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CONV_IDLE;
    else        state <= state_next;
  end

  // An abort wins over everything, including the DONE pulse of the old conversion.
  always_comb begin
    state_next = state;
    busy       = (state != CONV_IDLE);
    done       = 1'b0;
    case (state)
      CONV_IDLE:  if (start) state_next = CONV_LOAD;
      CONV_LOAD:  state_next = CONV_SHIFT;
      CONV_SHIFT: if (iter == 4'd10) state_next = CONV_DONE;
      CONV_DONE: begin
        done       = 1'b1;
        state_next = CONV_IDLE;
      end
      default:    state_next = CONV_IDLE;
    endcase
    if (abort) begin
      state_next = CONV_LOAD;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr   <= '0;
      iter <= '0;
    end else begin
      case (state)
        CONV_LOAD: begin
          sr   <= {16'd0, bin};
          iter <= '0;
        end
        CONV_SHIFT: begin
          sr   <= {sr_adj[25:0], 1'b0};
          iter <= iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_driver.sv
// Display back end: button debounce, mode select, BCD conversion, digit buffer and scanner.
module seg_display_driver
  import seg_display_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic           clk,
  input logic           reset,
  seg_display_if.slave  bus
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic            btn_s1, btn_s2, btn_acc, btn_acc_d, btn_armed;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  // Synchronizer resets high so a button held through reset never arms a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1    <= 1'b1;
      btn_s2    <= 1'b1;
      btn_acc   <= 1'b0;
      btn_acc_d <= 1'b0;
      btn_armed <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_s1    <= bus.mode_btn;
      btn_s2    <= btn_s1;
      btn_acc_d <= btn_acc;
      if (!btn_s2) btn_armed <= 1'b1;
      if (btn_s2 != btn_acc) begin
        if (db_cnt == DB_LAST) begin
          btn_acc <= btn_s2;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = btn_acc & ~btn_acc_d & btn_armed;

  mode_t mode_q, mode_prev;
  logic  mode_chg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= MODE_HEX;
      mode_prev <= MODE_HEX;
    end else begin
      mode_prev <= mode_q;
      if (press) begin
        if (mode_q == mode_t'(NUM_MODES - 1)) mode_q <= MODE_HEX;
        else                                  mode_q <= mode_t'(mode_q + 3'd1);
      end
    end
  end

  assign mode_chg = (mode_q != mode_prev);

  logic [10:0] sel_val, last_val;
  logic        is_cnt_mode;
  logic        conv_start, conv_abort, conv_busy, conv_done;
  logic [15:0] conv_bcd;
  conv_state_t conv_state;

  always_comb begin
    sel_val = 11'd0;
    case (mode_q)
      MODE_CLK: sel_val = bus.cnt_clk;
      MODE_I:   sel_val = bus.cnt_i;
      MODE_R:   sel_val = bus.cnt_r;
      MODE_J:   sel_val = bus.cnt_j;
      default:  sel_val = 11'd0;
    endcase
  end

  assign is_cnt_mode = (mode_q != MODE_HEX);
  assign conv_start  = is_cnt_mode && ((sel_val != last_val) || mode_chg);
  assign conv_abort  = mode_chg && conv_busy;

  // Mirrors the converter's snapshot so later input changes retrigger it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       last_val <= '0;
    else if (conv_state == CONV_LOAD) last_val <= sel_val;
  end

  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .reset     (reset),
    .start     (conv_start),
    .abort     (conv_abort),
    .bin       (sel_val),
    .busy      (conv_busy),
    .done      (conv_done),
    .bcd       (conv_bcd),
    .state_dbg (conv_state)
  );

  logic [31:0]           buf_nib;
  logic [NUM_DIGITS-1:0] buf_blank;
  mode_t                 buf_mode;
  logic [3:0]            lead_blank;

  assign lead_blank = {conv_bcd[15:12] == 4'd0,
                       conv_bcd[15:8]  == 8'd0,
                       conv_bcd[15:4]  == 12'd0,
                       1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_nib   <= '0;
      buf_blank <= '0;
      buf_mode  <= MODE_HEX;
    end else if (mode_q == MODE_HEX) begin
      buf_nib   <= bus.hex;
      buf_blank <= '0;
      buf_mode  <= MODE_HEX;
    end else if (conv_done) begin
      buf_nib   <= {16'd0, conv_bcd};
      buf_blank <= {4'b0111, lead_blank};
      buf_mode  <= mode_q;
    end
  end

  logic [SCAN_W-1:0]     presc;
  logic [2:0]            idx;
  logic [7:0]            digit_seg;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == SCAN_LAST) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    digit_seg = hex2seg(buf_nib[{idx, 2'b00} +: 4]);
    if (buf_mode != MODE_HEX && idx == 3'd7) digit_seg = mode_glyph(buf_mode);
    if (buf_blank[idx]) digit_seg = SEG_BLANK;
  end

  // seg and an are registered from the same index so they always move together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= 8'hC0;
      an_q  <= 8'hFE;
    end else begin
      seg_q <= digit_seg;
      an_q  <= ~(8'd1 << idx);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.mode       = mode_q;
  assign bus.conv_state = conv_state;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver with a fast scan and short debounce.
module tb_seg_display_driver;
  import seg_display_pkg::*;

  localparam int SCAN_DIV        = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_display_if ifc ();

  seg_display_driver #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] dec_seg(input int v, input logic [7:0] glyph, input int d);
    int p;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    if (d == 7) return glyph;
    if (d >= 4 || d < 0) return (d >= 4 && d < 7) ? 8'hFF : 8'h00;
    if (d > 0 && v < p) return 8'hFF;
    return seg_tab[(v / p) % 10];
  endfunction

  function automatic int an_digit(input logic [7:0] a);
    logic [7:0] m;
    for (int d = 0; d < 8; d++) begin
      m = ~(8'd1 << d);
      if (a === m) return d;
    end
    return 8;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic push_hex(input logic [31:0] h);
    logic [7:0] a;
    logic [3:0] nib;
    for (int d = 0; d < 8; d++) begin
      a   = ~(8'd1 << d);
      nib = h[4*d +: 4];
      exp_q.push_back({a, seg_tab[nib]});
    end
  endtask

  task automatic push_dec(input int v, input logic [7:0] glyph);
    logic [7:0] a;
    for (int d = 0; d < 8; d++) begin
      a = ~(8'd1 << d);
      exp_q.push_back({a, dec_seg(v, glyph, d)});
    end
  endtask

  task automatic drain(input string tag);
    logic [15:0] e;
    int t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = 0;
      while (ifc.an !== e[15:8] && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (t >= 40) check({tag, "_timeout"}, ifc.an, e[15:8]);
      else         check(tag, ifc.seg, e[7:0]);
    end
  endtask

  task automatic wait_state(input conv_state_t s, input string tag);
    int t;
    t = 0;
    while (ifc.conv_state != s && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) check({tag, "_timeout"}, 32'(ifc.conv_state), 32'(s));
  endtask

  // ---------------- driver ----------------
  task automatic press_clean();
    ifc.mode_btn = 1'b1;
    cycles(10);
    ifc.mode_btn = 1'b0;
    cycles(10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int loads;
    int dones;
    int done_at;
    int d;

    ifc.mode_btn = 1'b0;
    ifc.hex      = 32'h1234ABCD;
    ifc.cnt_clk  = 11'd2047;
    ifc.cnt_i    = 11'd100;
    ifc.cnt_r    = 11'd55;
    ifc.cnt_j    = 11'd1000;

    #2 reset = 1'b0;
    cycles(3);
    check("rst_mode",  ifc.mode, 3'd0);
    check("rst_an",    ifc.an, 8'hFE);
    check("rst_seg",   ifc.seg, 8'hC0);
    check("rst_state", 32'(ifc.conv_state), 32'(CONV_IDLE));

    reset = 1'b1;
    push_hex(32'h1234ABCD);
    cycles(2);
    drain("hex_scan");

    // Short pulse must be rejected.
    ifc.mode_btn = 1'b1;
    cycles(3);
    ifc.mode_btn = 1'b0;
    cycles(12);
    check("pulse_mode", ifc.mode, 3'd0);

    // Clean press: mode flips on the 7th edge after the button is first sampled.
    ifc.mode_btn = 1'b1;
    cycles(6);
    check("hold_p6", ifc.mode, 3'd0);
    cycles(1);
    check("hold_p7", ifc.mode, 3'd1);
    ifc.mode_btn = 1'b0;
    wait_state(CONV_LOAD, "load2047");
    lat = 1;
    while (ifc.conv_state != CONV_DONE && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("conv_latency", lat, 13);
    cycles(2);
    push_dec(2047, 8'hC6);
    drain("dec2047");

    ifc.cnt_clk = 11'd5;
    wait_state(CONV_DONE, "done5");
    cycles(2);
    push_dec(5, 8'hC6);
    drain("dec5");

    // Bounced press: the stability count restarts at the second rising sample.
    ifc.mode_btn = 1'b1;
    cycles(3);
    ifc.mode_btn = 1'b0;
    cycles(1);
    ifc.mode_btn = 1'b1;
    cycles(6);
    check("bounce_p10", ifc.mode, 3'd1);
    cycles(1);
    check("bounce_p11", ifc.mode, 3'd2);
    wait_state(CONV_SHIFT, "shift100");
    ifc.mode_btn = 1'b0;
    cycles(2);
    ifc.cnt_i = 11'd999;
    wait_state(CONV_DONE, "done100");
    cycles(1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      d = an_digit(ifc.an);
      check("snap100", ifc.seg, dec_seg(100, 8'hF9, d));
    end
    wait_state(CONV_DONE, "done999");
    cycles(2);
    push_dec(999, 8'hF9);
    drain("dec999");

    press_clean();
    check("mode_r", ifc.mode, 3'd3);
    wait_state(CONV_DONE, "done55");
    cycles(2);
    push_dec(55, 8'hAF);
    drain("dec55");

    // Input change starts a conversion; the press lands mid-SHIFT and aborts it.
    ifc.mode_btn = 1'b1;
    ifc.cnt_r    = 11'd77;
    loads   = 0;
    dones   = 0;
    done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 10) ifc.mode_btn = 1'b0;
      if (ifc.conv_state == CONV_LOAD) loads++;
      if (ifc.conv_state == CONV_DONE) begin
        dones++;
        done_at = k;
      end
    end
    check("mode_j",        ifc.mode, 3'd4);
    check("abort_loads",   loads, 2);
    check("abort_dones",   dones, 1);
    check("abort_done_at", done_at, 20);
    push_dec(1000, 8'hE1);
    drain("dec1000");

    ifc.hex = 32'h000000F0;
    press_clean();
    check("wrap_mode", ifc.mode, 3'd0);
    push_hex(32'h000000F0);
    drain("hex_noblank");

    // Asynchronous reset in the middle of a conversion.
    ifc.mode_btn = 1'b1;
    wait_state(CONV_SHIFT, "shift_rst");
    cycles(2);
    reset = 1'b0;
    #1;
    check("rstmid_mode",  ifc.mode, 3'd0);
    check("rstmid_an",    ifc.an, 8'hFE);
    check("rstmid_seg",   ifc.seg, 8'hC0);
    check("rstmid_state", 32'(ifc.conv_state), 32'(CONV_IDLE));
    ifc.mode_btn = 1'b0;
    cycles(3);
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ifc.conv_state == CONV_DONE) dones++;
    end
    check("no_stale_done", dones, 0);
    check("post_rst_mode", ifc.mode, 3'd0);

    // Button held through reset release is not a press.
    ifc.mode_btn = 1'b1;
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(15);
    check("held_rst_mode", ifc.mode, 3'd0);
    ifc.mode_btn = 1'b0;
    cycles(10);
    press_clean();
    check("repress_mode", ifc.mode, 3'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
